ram_stream_reader: RTL and testbench

- Read-side master for a simple dual-port RAM with 1-cycle registered read latency: raddr in cycle N gives read_data in cycle N+1.
- On a start command it walks a contiguous, wrapping address range and presents the words as a valid/ready stream.
- Full backpressure; never loses or duplicates a word.
- Sits between a frame/line buffer RAM's read port and downstream consumers (display/serializer).

---
 rtl/ram_stream_reader_pkg.sv | 18 +
 rtl/stream_skid_buffer.sv | 81 ++++++++
 rtl/ram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg
//   Shared types and constants for the RAM stream reader and its skid buffer.
//   - state_t   : burst controller states (IDLE, RUN, DRAIN, DONE)
//   - STATE_W   : encoded state width
//   - BUF_DEPTH : entries in the output skid buffer
package ram_stream_reader_pkg;

    localparam int STATE_W   = 2;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer
//   Two-entry FIFO used as the output stage of valid/ready stream blocks.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_data at the end of this cycle
//     push_data   : word to store
//     pop         : consumer took the head word this cycle
//     flush       : synchronous clear; overrides push and pop
//     head_data   : oldest word (zero when empty)
//     head_valid  : buffer holds at least one word
//     occupancy   : number of stored words (0..2)
//   A push while full is only honoured if a pop frees a slot in the same cycle.
module stream_skid_buffer
    import ram_stream_reader_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [SIZE-1:0] push_data,
    input  logic            pop,
    input  logic            flush,
    output logic [SIZE-1:0] head_data,
    output logic            head_valid,
    output logic [1:0]      occupancy
);

    logic [SIZE-1:0] mem_r [BUF_DEPTH];
    logic            rd_ptr_r;
    logic            wr_ptr_r;
    logic [1:0]      count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (count_r != 2'd0) begin
            do_pop_s = pop;
        end else begin
            do_pop_s = 1'b0;
        end
        if ((count_r != 2'd2) || do_pop_s) begin
            do_push_s = push;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage, pointers and fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

    assign head_valid = (count_r != 2'd0);
    assign head_data  = head_valid ? mem_r[rd_ptr_r] : '0;
    assign occupancy  = count_r;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read master for a dual-port RAM with one cycle of registered read latency.
//   A start command walks a wrapping address range [base_addr, +length) and
//   delivers the words in order on a valid/ready stream with full backpressure.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     start               : burst command, only sampled in IDLE
//     base_addr, length   : first address and word count (0..2*DEPTH-1)
//     busy, done          : controller not idle / one-cycle completion pulse
//     raddr, read_data    : RAM read port
//     out_data, out_valid, out_ready : output stream
//     abort               : only when RAM_STREAM_READER_ABORT_EN is defined;
//                           ends a running burst early (flush, then done)
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter  int SIZE  = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW:0]     length,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   raddr,
    input  logic [SIZE-1:0] read_data,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] ptr_r;
    logic [AW:0]   remaining_r;
    logic          inflight_r;
    logic          abort_s;
    logic          pop_s;
    logic          issue_s;
    logic [2:0]    credit_s;
    logic [1:0]    occ_s;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + 1'b1;
        end
    endfunction

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_s = abort && ((state_r == RUN) || (state_r == DRAIN));
`else
    assign abort_s = 1'b0;
`endif

    // Abort wins over a same-cycle handshake: that word is not consumed.
    assign pop_s = out_valid && out_ready && !abort_s;

    // Words already buffered or in flight, after this cycle's pop, must leave
    // room for one more so a newly issued read always has a slot to land in.
    always_comb begin
        credit_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        if ((state_r == RUN) && !abort_s && (credit_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic for the burst controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (length == '0) ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_nxt_s = DONE;
                end else if (issue_s && (remaining_r == {{AW{1'b0}}, 1'b1})) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                // Leave as soon as the last word is handshaken this cycle so
                // done lands in the cycle right after the final transfer.
                if (abort_s) begin
                    state_nxt_s = DONE;
                end else if (!inflight_r && ((occ_s - {1'b0, pop_s}) == 2'd0)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read pointer (drives raddr directly), remaining count and in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            remaining_r <= '0;
            inflight_r  <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if ((state_r == IDLE) && start) begin
                ptr_r       <= base_addr;
                remaining_r <= length;
            end else if (issue_s) begin
                ptr_r       <= next_ptr(ptr_r);
                remaining_r <= remaining_r - {{AW{1'b0}}, 1'b1};
            end else begin
                ptr_r       <= ptr_r;
                remaining_r <= remaining_r;
            end
        end
    end

    stream_skid_buffer #(
        .SIZE(SIZE)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_r && !abort_s),
        .push_data  (read_data),
        .pop        (pop_s),
        .flush      (abort_s),
        .head_data  (out_data),
        .head_valid (out_valid),
        .occupancy  (occ_s)
    );

    assign raddr = ptr_r;
    assign busy  = (state_r != IDLE);
    assign done  = (state_r == DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Scoreboard bench: expected words are queued when a burst is started and
//   popped on every output handshake. A RAM model with one cycle read latency
//   holds mem[i] = 0x10 + i.
module tb_ram_stream_reader;

    localparam int SIZE  = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     length;
    logic            busy;
    logic            done;
    logic [AW-1:0]   raddr;
    logic [SIZE-1:0] read_data;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            abort_tb;

    logic [SIZE-1:0] mem [DEPTH];
    logic [SIZE-1:0] exp_q [$];

    int   checks_cnt = 0;
    int   errors_cnt = 0;

    bit   mon_en = 1'b0;
    bit   bp_chk = 1'b0;
    bit   bp_mode = 1'b0;
    int   rel;
    int   first_valid_rel;
    int   done_rel;
    int   done_cnt;
    int   busy_bad;
    int   words;
    bit   prev_stall;
    logic [SIZE-1:0] prev_data;
    logic [AW-1:0]   base_chk;
    logic [AW-1:0]   diff_v;

    ram_stream_reader #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort     (abort_tb),
`endif
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .read_data (read_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // RAM model: registered read.
    always @(posedge clk) read_data <= mem[raddr];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Ready pattern: constant 1, or 1,0,0 repeating in backpressure mode.
    initial begin
        int phase = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? (phase == 0) : 1'b1;
            phase = (phase + 1) % 3;
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            rel++;
            if (out_valid && (first_valid_rel < 0)) first_valid_rel = rel;
            if (!busy && (done_cnt == 0)) busy_bad++;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (prev_stall) begin
                check_val("stall_valid", 32'(out_valid), 32'd1);
                check_val("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (bp_chk) begin
                diff_v = raddr - base_chk;
                check_val("ahead_le2", 32'((int'(diff_v) - words) <= 2), 32'd1);
            end
            if (out_valid && out_ready && !abort_tb) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check_val("data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                words++;
            end
            prev_stall = out_valid && !out_ready && !abort_tb;
            prev_data  = out_data;
        end
    end

    task automatic begin_burst(input logic [AW-1:0] b, input logic [AW:0] l, input bit chk);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(8'h10 + 8'((int'(b) + i) % DEPTH));
        end
        @(posedge clk);
        #1;
        start           = 1'b0;
        rel             = 0;
        first_valid_rel = -1;
        done_rel        = -1;
        done_cnt        = 0;
        busy_bad        = 0;
        words           = 0;
        prev_stall      = 1'b0;
        base_chk        = b;
        bp_chk          = chk;
        mon_en          = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int exp_done, input int exp_first, input int exp_left);
        int n = 0;
        while ((done_cnt == 0) && (n < 80)) begin
            @(posedge clk);
            n++;
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        mon_en = 1'b0;
        bp_chk = 1'b0;
        if (exp_done >= 0) check_val({tag, "_done_cycle"}, 32'(done_rel), 32'(exp_done));
        check_val({tag, "_first_valid"}, 32'(first_valid_rel), 32'(exp_first));
        check_val({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check_val({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check_val({tag, "_left"}, 32'(exp_q.size()), 32'(exp_left));
        exp_q.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 3'd0;
        length    = 4'd0;
        abort_tb  = 1'b0;
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_raddr", 32'(raddr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic burst, one word per cycle.
        begin_burst(3'd2, 4'd4, 1'b0);
        wait_done("basic", 7, 3, 0);

        // Wrapping burst with address sequence check.
        begin_burst(3'd6, 4'd5, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_val("wrap_raddr", 32'(raddr), 32'((6 + k - 1) % DEPTH));
        end
        wait_done("wrap", 8, 3, 0);

        // Backpressure: ready 1,0,0 repeating.
        bp_mode = 1'b1;
        begin_burst(3'd0, 4'd6, 1'b1);
        wait_done("bp", -1, 3, 0);
        bp_mode = 1'b0;
        @(posedge clk);
        #2;

        // Zero-length burst.
        begin_burst(3'd3, 4'd0, 1'b0);
        wait_done("len0", 1, -1, 0);

        // Start while busy is ignored.
        begin_burst(3'd1, 4'd4, 1'b0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 3'd5;
        length    = 4'd2;
        @(posedge clk);
        #1;
        start     = 1'b0;
        wait_done("busy_start", 7, 3, 0);

        // Reset in the middle of a burst.
        begin_burst(3'd0, 4'd6, 1'b0);
        n = 0;
        while ((words < 2) && (n < 40)) begin
            @(posedge clk);
            n++;
        end
        check_val("rst_mid_words", 32'(words), 32'd2);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", 32'(out_valid), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_done", 32'(done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        begin_burst(3'd5, 4'd3, 1'b0);
        wait_done("after_rst", 6, 3, 0);

`ifdef RAM_STREAM_READER_ABORT_EN
        // Abort after the first word; the word offered that cycle is dropped.
        begin_burst(3'd0, 4'd5, 1'b0);
        n = 0;
        while ((words < 1) && (n < 40)) begin
            @(posedge clk);
            n++;
        end
        #1;
        abort_tb = 1'b1;
        @(posedge clk);
        #1;
        abort_tb = 1'b0;
        @(negedge clk);
        check_val("abort_valid", 32'(out_valid), 32'd0);
        check_val("abort_done", 32'(done), 32'd1);
        wait_done("abort", 5, 3, 4);
        check_val("abort_words", 32'(words), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
